add1x1_registered: RTL and testbench
====================================

// Module: add1x1_registered
// PURPOSE
//   1-bit full adder (sum/carry of a, b, cin) with a registered output stage and
//   a valid qualifier. Optional bit-serial mode feeds the registered carry back
//   as carry-in, so multi-bit operands can be added LSB-first, one bit per cycle.
//   Arithmetic leaf cell of the sequential y86 datapath (ALU add/sub chains).
// PARAMETERS
//   REG_OUT   1  1: outputs registered, 1-cycle latency; 0: sum/co/out_valid combinational
//   SERIAL_EN 1  1: serial_mode/serial_start honoured; 0: those inputs ignored, cin always used
// PORTS
//   clk           in   1  rising-edge clock
//   rst_n         in   1  reset; asynchronous, active-low
//   a             in   1  operand bit A
//   b             in   1  operand bit B
//   cin           in   1  external carry-in
//   in_valid      in   1  a/b/cin (and mode bits) valid this cycle
//   serial_mode   in   1  1: carry-in taken from internal carry register
//   serial_start  in   1  first bit of a serial word; forces use of external cin
//   sum           out  1  a ^ b ^ cin_eff
//   co            out  1  carry-out: majority(a, b, cin_eff)
//   out_valid     out  1  sum/co hold a freshly computed result
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst_n is asynchronous, active-low.
//   - cin_eff = (SERIAL_EN && serial_mode && !serial_start) ? carry_q : cin.
//   - Core: s = a^b^cin_eff; c = (a&b)|(a&cin_eff)|(b&cin_eff). Pure 1-bit, no overflow flag.
//   - Reset (rst_n=0, async): sum=0, co=0, out_valid=0, carry_q=0; hold while low.
//   - REG_OUT=1: on rising clk with in_valid=1 -> sum<=s, co<=c, out_valid<=1,
//     carry_q<=c. With in_valid=0 -> sum/co/carry_q hold, out_valid<=0.
//     Latency exactly 1 cycle; a new bit can be accepted every cycle.
//   - REG_OUT=0: sum=s, co=c, out_valid=in_valid combinationally; carry_q still
//     updates on clk when in_valid=1 (serial mode remains functional).
//   - Serial word: assert serial_mode on every bit; serial_start=1 on bit 0
//     (cin is then the word carry-in, 0 for add, 1 for subtract-by-complement).
//     Bit k>0 uses carry_q from bit k-1. Gaps (in_valid=0) between bits allowed;
//     carry_q is preserved across gaps.
//   - serial_start=1 with serial_mode=0: ignored (cin used, same as non-serial).
//   - Reset mid-word: carry_q cleared; next word must begin with serial_start.
//   - No X propagation on outputs after reset; all outputs driven at all times.
// TESTING
//   - Reset: rst_n=0 async mid-cycle -> sum=0, co=0, out_valid=0 immediately.
//   - Truth vectors (a,b,cin, in_valid=1, serial_mode=0), REG_OUT=1, one cycle later:
//     000->sum0 co0; 100->sum1 co0; 110->sum0 co1; 101->sum0 co1; 111->sum1 co1.
//   - in_valid=0 after 110: sum=0, co=1 hold; out_valid drops to 0 next cycle.
//   - Serial 3+1 (4 bits, LSB first: a=1,1,0,0 b=1,0,0,0, cin=0, start on bit 0)
//     -> sum bits 0,0,1,0 (=4), co of last bit=0; repeat 15+1 -> sum 0000, co=1.
//   - Serial gap + reset: in_valid low 3 cycles between bits preserves carry;
//     rst_n pulse mid-word clears carry_q, next non-start bit uses carry 0.
//   - REG_OUT=0 build: sum/co follow inputs with zero cycles latency, same truth table.

Source files
------------

// File: rtl/add1x1_registered.sv
// 1-bit full adder leaf cell with optional registered output stage and a
// carry feedback register, so multi-bit operands can be summed LSB-first,
// one bit per cycle, through the same cell.
module add1x1_registered #(
   parameter bit REG_OUT   = 1'b1,
   parameter bit SERIAL_EN = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic in_valid,
   input  logic serial_mode,
   input  logic serial_start,
   output logic sum,
   output logic co,
   output logic out_valid
);

   localparam int STAGES = 1;

   logic carry_q;
   logic cin_eff;
   logic s;
   logic c;

   // Bits after the first one of a serial word chain from the stored carry;
   // serial_start or non-serial operation always takes the external carry-in.
   assign cin_eff = (SERIAL_EN && serial_mode && !serial_start) ? carry_q : cin;
   assign s       = a ^ b ^ cin_eff;
   assign c       = (a & b) | (a & cin_eff) | (b & cin_eff);

   // Carry register tracks the carry of the last accepted bit; held across gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        carry_q <= 1'b0;
      else if (in_valid) carry_q <= c;
   end

   generate
      if (REG_OUT) begin : g_reg
         logic [STAGES:0] vld_pipe;
         logic            sum_q;
         logic            co_q;

         assign vld_pipe[0] = in_valid;

         // Valid qualifier advances every cycle; it drops when no bit arrives.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vld_pipe[STAGES:1] <= '0;
            else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         end

         // Result registers load on accepted bits only and hold otherwise.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sum_q <= 1'b0;
               co_q  <= 1'b0;
            end else if (in_valid) begin
               sum_q <= s;
               co_q  <= c;
            end
         end

         assign sum       = sum_q;
         assign co        = co_q;
         assign out_valid = vld_pipe[STAGES];
      end else begin : g_comb
         assign sum       = s;
         assign co        = c;
         assign out_valid = in_valid;
      end
   endgenerate

endmodule

// File: tb/tb_add1x1_registered.sv
// Randomized scoreboard bench for add1x1_registered: a registered instance is
// checked through a queue of expected results, and a combinational instance
// sharing the same inputs is checked in the same cycle.
module tb_add1x1_registered;

   typedef struct packed {
      logic s;
      logic c;
      logic ser;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a = 1'b0, b = 1'b0, cin = 1'b0, in_valid = 1'b0;
   logic serial_mode = 1'b0, serial_start = 1'b0;
   logic sum, co, out_valid;
   logic sum0, co0, ov0;

   int checks = 0;
   int errors = 0;

   exp_t sbq[$];
   int   mc = 0;
   logic last_s = 1'b0, last_c = 1'b0;
   logic exp_s_now = 1'b0, exp_c_now = 1'b0, exp_v_now = 1'b0;
   logic [15:0] word_bits;
   int   word_cnt = 0;
   logic word_co = 1'b0;

   add1x1_registered #(.REG_OUT(1'b1), .SERIAL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
      .serial_mode(serial_mode), .serial_start(serial_start),
      .sum(sum), .co(co), .out_valid(out_valid));

   add1x1_registered #(.REG_OUT(1'b0), .SERIAL_EN(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
      .serial_mode(serial_mode), .serial_start(serial_start),
      .sum(sum0), .co(co0), .out_valid(ov0));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: pop on every registered output, otherwise verify hold.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         if (sbq.size() == 0) chk("spurious_valid", 1, 0);
         else begin
            e = sbq.pop_front();
            chk("sum", int'(sum), int'(e.s));
            chk("co", int'(co), int'(e.c));
            last_s = e.s;
            last_c = e.c;
            if (e.ser && word_cnt < 16) begin
               word_bits[word_cnt] = sum;
               word_cnt++;
               word_co = co;
            end
         end
      end else begin
         chk("out_valid", int'(out_valid), 0);
         chk("hold_sum", int'(sum), int'(last_s));
         chk("hold_co", int'(co), int'(last_c));
      end
      chk("comb_valid", int'(ov0), int'(exp_v_now));
      if (exp_v_now) begin
         chk("comb_sum", int'(sum0), int'(exp_s_now));
         chk("comb_co", int'(co0), int'(exp_c_now));
      end
   end

   task automatic send(input logic ia, ib, ic, im, ist, iser);
      int ce, tot;
      exp_t e;
      a = ia; b = ib; cin = ic; serial_mode = im; serial_start = ist;
      in_valid = 1'b1;
      ce  = (im && !ist) ? mc : int'(ic);
      tot = int'(ia) + int'(ib) + ce;
      exp_s_now = (tot % 2) == 1;
      exp_c_now = (tot / 2) == 1;
      exp_v_now = 1'b1;
      e.s = exp_s_now; e.c = exp_c_now; e.ser = iser;
      sbq.push_back(e);
      mc = tot / 2;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a = 1'($urandom); b = 1'($urandom); cin = 1'($urandom);
      serial_mode = 1'($urandom); serial_start = 1'($urandom);
      exp_v_now = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle();
      @(negedge clk); #2;
      rst_n = 1'b0;
      last_s = 1'b0; last_c = 1'b0; mc = 0;
      sbq.delete();
      #1;
      chk("rst_sum", int'(sum), 0);
      chk("rst_co", int'(co), 0);
      chk("rst_valid", int'(out_valid), 0);
      @(posedge clk); @(negedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic word(input int wa, input int wb, input logic c0, input int n, input int gap);
      int tot;
      word_cnt = 0;
      for (int k = 0; k < n; k++) begin
         send(1'(wa >> k), 1'(wb >> k), (k == 0) ? c0 : 1'($urandom), 1'b1, k == 0, 1'b1);
         if (k < n - 1) repeat (gap) idle();
      end
      idle();
      @(negedge clk); #1;
      tot = wa + wb + int'(c0);
      chk("word_bits", int'(word_bits) & ((1 << n) - 1), tot & ((1 << n) - 1));
      chk("word_co", int'(word_co), (tot >> n) & 1);
      chk("word_cnt", word_cnt, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      do_reset();

      // truth vectors, non-serial
      send(0, 0, 0, 0, 0, 0);
      send(1, 0, 0, 0, 0, 0);
      send(1, 1, 0, 0, 0, 0);
      idle(); idle();
      send(1, 0, 1, 0, 0, 0);
      send(1, 1, 1, 0, 0, 0);
      send(0, 1, 1, 0, 1, 0);
      idle();

      // serial words
      word(3, 1, 1'b0, 4, 0);
      word(15, 1, 1'b0, 4, 0);
      word(5, 6, 1'b0, 4, 3);
      word(9, 14, 1'b1, 4, 1);

      // reset mid-word clears the chained carry
      send(1, 1, 0, 1, 1, 0);
      do_reset();
      send(0, 0, 1, 1, 0, 0);
      idle();

      // random words with random gaps
      for (int i = 0; i < 20; i++)
         word(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              1'($urandom), 8, int'($urandom_range(0, 2)));

      // random bit traffic with random modes and gaps
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         else send(1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
      end
      idle();
      @(negedge clk); #1;
      chk("queue_drained", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
